// File: rtl/rs_entry_alloc.sv
// Reservation-station occupancy and wakeup tracker: allocates up to two free
// slots per cycle, snoops two CDB tags for operand wakeup, and frees issued slots.
module rs_entry_alloc #(
    parameter int TAG_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             disp1_en,
    input  logic [TAG_W-1:0] disp1_src1_tag,
    input  logic [TAG_W-1:0] disp1_src2_tag,
    input  logic             disp1_src1_rdy,
    input  logic             disp1_src2_rdy,
    input  logic             disp2_en,
    input  logic [TAG_W-1:0] disp2_src1_tag,
    input  logic [TAG_W-1:0] disp2_src2_tag,
    input  logic             disp2_src1_rdy,
    input  logic             disp2_src2_rdy,
    input  logic             cdb1_valid,
    input  logic [TAG_W-1:0] cdb1_tag,
    input  logic             cdb2_valid,
    input  logic [TAG_W-1:0] cdb2_tag,
    input  logic [3:0]       issue1,
    input  logic             issue1_en,
    input  logic [3:0]       issue2,
    input  logic             issue2_en,
    output logic [3:0]       disp1_idx,
    output logic [3:0]       disp2_idx,
    output logic             disp1_ok,
    output logic             disp2_ok,
    output logic [15:0]      ready_vec,
    output logic [4:0]       free_cnt,
    output logic             rs_full1,
    output logic             rs_full2
);

    logic [15:0]      valid;
    logic [15:0]      src1_rdy;
    logic [15:0]      src2_rdy;
    logic [TAG_W-1:0] src1_tag [16];
    logic [TAG_W-1:0] src2_tag [16];

    logic [15:0] free_vec;
    logic [3:0]  lo_idx;
    logic [3:0]  hi_idx;
    logic [15:0] issue_clr;

    function automatic logic cdb_hit(input logic [TAG_W-1:0] tag);
        return (cdb1_valid && (tag == cdb1_tag)) || (cdb2_valid && (tag == cdb2_tag));
    endfunction

    // Slot search and counting look only at registered state, so a slot
    // freed by issue this cycle is not offered until the next one.
    always_comb begin
        free_vec = ~valid;
        lo_idx   = 4'd0;
        hi_idx   = 4'd0;
        free_cnt = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (free_vec[i]) lo_idx = 4'(i);
        end
        for (int i = 0; i < 16; i++) begin
            if (free_vec[i]) hi_idx = 4'(i);
            free_cnt = free_cnt + {4'd0, free_vec[i]};
        end
    end

    always_comb begin
        disp1_idx = lo_idx;
        disp2_idx = disp1_en ? hi_idx : lo_idx;
        rs_full1  = (free_cnt == 5'd0);
        rs_full2  = (free_cnt < 5'd2);
        disp1_ok  = disp1_en && !rs_full1;
        disp2_ok  = disp2_en && (disp1_en ? !rs_full2 : !rs_full1);
        ready_vec = valid & src1_rdy & src2_rdy;
        issue_clr = 16'd0;
        if (issue1_en) issue_clr[issue1] = 1'b1;
        if (issue2_en) issue_clr[issue2] = 1'b1;
    end

    // Dispatch only targets free slots, so it never collides with issue or
    // wakeup of the same entry; it is applied last for clarity.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid    <= '0;
            src1_rdy <= '0;
            src2_rdy <= '0;
            for (int i = 0; i < 16; i++) begin
                src1_tag[i] <= '0;
                src2_tag[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (valid[i]) begin
                    if (issue_clr[i]) valid[i] <= 1'b0;
                    if (cdb_hit(src1_tag[i])) src1_rdy[i] <= 1'b1;
                    if (cdb_hit(src2_tag[i])) src2_rdy[i] <= 1'b1;
                end
            end
            if (disp1_ok) begin
                valid[disp1_idx]    <= 1'b1;
                src1_tag[disp1_idx] <= disp1_src1_tag;
                src2_tag[disp1_idx] <= disp1_src2_tag;
                src1_rdy[disp1_idx] <= disp1_src1_rdy || cdb_hit(disp1_src1_tag);
                src2_rdy[disp1_idx] <= disp1_src2_rdy || cdb_hit(disp1_src2_tag);
            end
            if (disp2_ok) begin
                valid[disp2_idx]    <= 1'b1;
                src1_tag[disp2_idx] <= disp2_src1_tag;
                src2_tag[disp2_idx] <= disp2_src2_tag;
                src1_rdy[disp2_idx] <= disp2_src1_rdy || cdb_hit(disp2_src1_tag);
                src2_rdy[disp2_idx] <= disp2_src2_rdy || cdb_hit(disp2_src2_tag);
            end
        end
    end

endmodule

// File: tb/tb_rs_entry_alloc.sv
// Directed bench for rs_entry_alloc: allocation order, wakeup/bypass timing,
// full boundaries, issue-to-free latency and asynchronous reset.
module tb_rs_entry_alloc;

    localparam int TAG_W = 6;

    logic             clock;
    logic             reset;
    logic             disp1_en, disp2_en;
    logic [TAG_W-1:0] disp1_src1_tag, disp1_src2_tag, disp2_src1_tag, disp2_src2_tag;
    logic             disp1_src1_rdy, disp1_src2_rdy, disp2_src1_rdy, disp2_src2_rdy;
    logic             cdb1_valid, cdb2_valid;
    logic [TAG_W-1:0] cdb1_tag, cdb2_tag;
    logic [3:0]       issue1, issue2;
    logic             issue1_en, issue2_en;
    logic [3:0]       disp1_idx, disp2_idx;
    logic             disp1_ok, disp2_ok;
    logic [15:0]      ready_vec;
    logic [4:0]       free_cnt;
    logic             rs_full1, rs_full2;

    int check_count = 0;
    int fail_count  = 0;

    rs_entry_alloc #(.TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset),
        .disp1_en(disp1_en), .disp1_src1_tag(disp1_src1_tag), .disp1_src2_tag(disp1_src2_tag),
        .disp1_src1_rdy(disp1_src1_rdy), .disp1_src2_rdy(disp1_src2_rdy),
        .disp2_en(disp2_en), .disp2_src1_tag(disp2_src1_tag), .disp2_src2_tag(disp2_src2_tag),
        .disp2_src1_rdy(disp2_src1_rdy), .disp2_src2_rdy(disp2_src2_rdy),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb2_valid(cdb2_valid), .cdb2_tag(cdb2_tag),
        .issue1(issue1), .issue1_en(issue1_en), .issue2(issue2), .issue2_en(issue2_en),
        .disp1_idx(disp1_idx), .disp2_idx(disp2_idx), .disp1_ok(disp1_ok), .disp2_ok(disp2_ok),
        .ready_vec(ready_vec), .free_cnt(free_cnt), .rs_full1(rs_full1), .rs_full2(rs_full2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyIdle();
        disp1_en = 0; disp2_en = 0;
        disp1_src1_tag = '0; disp1_src2_tag = '0; disp2_src1_tag = '0; disp2_src2_tag = '0;
        disp1_src1_rdy = 0; disp1_src2_rdy = 0; disp2_src1_rdy = 0; disp2_src2_rdy = 0;
        cdb1_valid = 0; cdb1_tag = '0; cdb2_valid = 0; cdb2_tag = '0;
        issue1 = '0; issue1_en = 0; issue2 = '0; issue2_en = 0;
    endtask

    // Advance to just after the next rising edge, then return inputs to idle.
    task automatic applyStimulus();
        @(posedge clock);
        #1;
        applyIdle();
        #1;
    endtask

    initial begin
        applyIdle();
        reset = 1'b1;
        #2;
        checkOutput("rst_ready_vec", 32'(ready_vec), 32'h0);
        checkOutput("rst_free_cnt", 32'(free_cnt), 32'd16);
        checkOutput("rst_full1", 32'(rs_full1), 32'd0);
        checkOutput("rst_full2", 32'(rs_full2), 32'd0);
        checkOutput("rst_disp1_idx", 32'(disp1_idx), 32'd0);
        checkOutput("rst_disp2_idx_noa", 32'(disp2_idx), 32'd0);
        disp1_en = 1; #1;
        checkOutput("rst_disp2_idx_a", 32'(disp2_idx), 32'd15);
        disp1_en = 0;
        #4 reset = 1'b0;
        applyStimulus();

        // Two ready instructions together
        disp1_en = 1; disp1_src1_rdy = 1; disp1_src2_rdy = 1;
        disp2_en = 1; disp2_src1_rdy = 1; disp2_src2_rdy = 1;
        #1;
        checkOutput("pair_idx1", 32'(disp1_idx), 32'd0);
        checkOutput("pair_idx2", 32'(disp2_idx), 32'd15);
        checkOutput("pair_ok1", 32'(disp1_ok), 32'd1);
        checkOutput("pair_ok2", 32'(disp2_ok), 32'd1);
        applyStimulus();
        checkOutput("pair_ready_vec", 32'(ready_vec), 32'h8001);
        checkOutput("pair_free_cnt", 32'(free_cnt), 32'd14);

        // Slot B alone takes the lowest free slot; src1 waits on tag 9
        disp2_en = 1; disp2_src1_tag = 6'd9; disp2_src2_rdy = 1;
        #1;
        checkOutput("solo2_idx", 32'(disp2_idx), 32'd1);
        checkOutput("solo2_ok", 32'(disp2_ok), 32'd1);
        applyStimulus();
        checkOutput("wait9_cyc1", 32'(ready_vec), 32'h8001);
        applyStimulus();
        checkOutput("wait9_cyc2", 32'(ready_vec), 32'h8001);
        cdb1_valid = 1; cdb1_tag = 6'd9; #1;
        checkOutput("wait9_same_cycle", 32'(ready_vec), 32'h8001);
        applyStimulus();
        checkOutput("wake9", 32'(ready_vec), 32'h8003);

        // Same-cycle bypass on tag 5 into slot 2
        disp1_en = 1; disp1_src1_tag = 6'd5; disp1_src2_tag = 6'd5;
        cdb2_valid = 1; cdb2_tag = 6'd5;
        applyStimulus();
        checkOutput("bypass_ready", 32'(ready_vec), 32'h8007);
        checkOutput("bypass_free", 32'(free_cnt), 32'd12);

        // Non-matching broadcast leaves slot 3 waiting on tag 7
        disp1_en = 1; disp1_src1_tag = 6'd7; disp1_src2_rdy = 1;
        cdb1_valid = 1; cdb1_tag = 6'd8;
        applyStimulus();
        checkOutput("nomatch_ready", 32'(ready_vec), 32'h8007);

        // Fill from both ends to 15 entries, leaving only slot 9 free
        for (int k = 0; k < 5; k++) begin
            disp1_en = 1; disp1_src1_rdy = 1; disp1_src2_rdy = 1;
            disp2_en = 1; disp2_src1_rdy = 1; disp2_src2_rdy = 1;
            applyStimulus();
        end
        checkOutput("fill_free", 32'(free_cnt), 32'd1);
        checkOutput("fill_full1", 32'(rs_full1), 32'd0);
        checkOutput("fill_full2", 32'(rs_full2), 32'd1);
        disp1_en = 1; disp1_src1_rdy = 1; disp1_src2_rdy = 1;
        disp2_en = 1; disp2_src1_rdy = 1; disp2_src2_rdy = 1;
        #1;
        checkOutput("last_idx1", 32'(disp1_idx), 32'd9);
        checkOutput("last_ok1", 32'(disp1_ok), 32'd1);
        checkOutput("last_ok2", 32'(disp2_ok), 32'd0);
        applyStimulus();
        checkOutput("full_full1", 32'(rs_full1), 32'd1);
        checkOutput("full_free", 32'(free_cnt), 32'd0);
        checkOutput("full_ready", 32'(ready_vec), 32'hFFF7);

        // Issue slot 3 while full: dispatch rejected, slot reused next cycle
        issue1 = 4'd3; issue1_en = 1; disp1_en = 1; disp1_src1_rdy = 1; disp1_src2_rdy = 1;
        #1;
        checkOutput("iss_full_ok1", 32'(disp1_ok), 32'd0);
        checkOutput("iss_full_free", 32'(free_cnt), 32'd0);
        applyStimulus();
        checkOutput("iss_freed_cnt", 32'(free_cnt), 32'd1);
        disp1_en = 1; disp1_src1_rdy = 1; disp1_src2_rdy = 1;
        disp2_en = 1; disp2_src1_rdy = 1; disp2_src2_rdy = 1;
        #1;
        checkOutput("reuse_idx1", 32'(disp1_idx), 32'd3);
        checkOutput("reuse_ok1", 32'(disp1_ok), 32'd1);
        checkOutput("reuse_ok2", 32'(disp2_ok), 32'd0);
        applyStimulus();
        checkOutput("reuse_ready", 32'(ready_vec), 32'hFFFF);

        // Duplicate issue clears once; issue of an invalid entry is ignored
        issue1 = 4'd0; issue1_en = 1; issue2 = 4'd0; issue2_en = 1;
        applyStimulus();
        checkOutput("dup_issue_free", 32'(free_cnt), 32'd1);
        issue1 = 4'd0; issue1_en = 1; issue2 = 4'd5; issue2_en = 1;
        applyStimulus();
        checkOutput("stale_issue_free", 32'(free_cnt), 32'd2);
        disp1_en = 1; #1;
        checkOutput("lohi_idx1", 32'(disp1_idx), 32'd0);
        checkOutput("lohi_idx2", 32'(disp2_idx), 32'd5);
        disp1_en = 0;
        issue1 = 4'd6; issue1_en = 1; issue2 = 4'd7; issue2_en = 1;
        applyStimulus();
        issue1 = 4'd8; issue1_en = 1; issue2 = 4'd10; issue2_en = 1;
        applyStimulus();
        checkOutput("pre_rst_ready", 32'(ready_vec), 32'hFA1E);
        checkOutput("pre_rst_free", 32'(free_cnt), 32'd6);

        // Asynchronous reset mid-cycle with 10 entries valid
        #2 reset = 1'b1;
        #1;
        checkOutput("async_rst_ready", 32'(ready_vec), 32'h0);
        checkOutput("async_rst_free", 32'(free_cnt), 32'd16);
        disp1_en = 1; disp1_src1_rdy = 1; disp1_src2_rdy = 1;
        applyStimulus();
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_drop_free", 32'(free_cnt), 32'd16);
        checkOutput("rst_drop_ready", 32'(ready_vec), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
